reg_fifo: RTL and testbench

//   Small synchronous FIFO built from edge-triggered storage registers.

---
 rtl/reg_fifo_if.sv | 24 ++
 rtl/reg_fifo.sv | 48 ++++
 tb/tb_reg_fifo.sv | 138 +++++++++++++
 3 files changed

// File: rtl/reg_fifo_if.sv
// reg_fifo_if: producer/consumer bus of reg_fifo; master drives requests, slave is the FIFO.
interface reg_fifo_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
);
  localparam int AW = $clog2(DEPTH);
  logic             wr_en;
  logic [WIDTH-1:0] wr_data;
  logic             rd_en;
  logic [WIDTH-1:0] rd_data;
  logic             full;
  logic             empty;
  logic [AW:0]      count;
  logic             overflow;
  logic             underflow;
  modport master (
    output wr_en, wr_data, rd_en,
    input  rd_data, full, empty, count, overflow, underflow
  );
  modport slave (
    input  wr_en, wr_data, rd_en,
    output rd_data, full, empty, count, overflow, underflow
  );
endinterface

// File: rtl/reg_fifo.sv
// reg_fifo: small flip-flop based show-ahead FIFO with occupancy count and overflow/underflow pulses.
module reg_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst_n,
  reg_fifo_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             r_overflow;
  logic             r_underflow;
  logic             w_full;
  logic             w_empty;
  logic             w_wr_acc;
  logic             w_rd_acc;
  assign w_full   = r_count == (AW+1)'(DEPTH);
  assign w_empty  = r_count == '0;
  // a write into a full FIFO is still legal when the same edge pops the head
  assign w_wr_acc = bus.wr_en & (~w_full | bus.rd_en);
  assign w_rd_acc = bus.rd_en & ~w_empty;
  always_ff @(posedge clk)
    if (w_wr_acc) r_mem[r_wr_ptr] <= bus.wr_data;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_wr_ptr    <= r_wr_ptr + AW'(w_wr_acc);
      r_rd_ptr    <= r_rd_ptr + AW'(w_rd_acc);
      r_count     <= r_count + (AW+1)'(w_wr_acc) - (AW+1)'(w_rd_acc);
      r_overflow  <= bus.wr_en & ~w_wr_acc;
      r_underflow <= bus.rd_en & w_empty;
    end
  assign bus.rd_data   = r_mem[r_rd_ptr];
  assign bus.full      = w_full;
  assign bus.empty     = w_empty;
  assign bus.count     = r_count;
  assign bus.overflow  = r_overflow;
  assign bus.underflow = r_underflow;
endmodule

// File: tb/tb_reg_fifo.sv
// tb_reg_fifo: directed self-checking bench for reg_fifo (WIDTH=8, DEPTH=4).
module tb_reg_fifo;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  reg_fifo_if #(.WIDTH(8), .DEPTH(4)) ff_if();
  reg_fifo #(.WIDTH(8), .DEPTH(4)) dut (.clk(clk), .rst_n(rst_n), .bus(ff_if.slave));
  always #5 clk = ~clk;

  // one clock cycle of stimulus; returns 1 time unit after the edge with requests idle
  task automatic cyc(input logic we, input logic [7:0] wd, input logic re);
    ff_if.wr_en = we;
    ff_if.wr_data = wd;
    ff_if.rd_en = re;
    @(posedge clk);
    #1;
    ff_if.wr_en = 1'b0;
    ff_if.rd_en = 1'b0;
  endtask

  task automatic test_reset;
    ff_if.wr_en = 1'b0;
    ff_if.rd_en = 1'b0;
    ff_if.wr_data = '0;
    rst_n = 1'b0;
    #2;
    checks++; if (ff_if.count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d want 0", ff_if.count); end
    checks++; if (ff_if.empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %b want 1", ff_if.empty); end
    checks++; if (ff_if.full !== 1'b0) begin errors++; $display("FAIL reset_full got %b want 0", ff_if.full); end
    checks++; if ({ff_if.overflow, ff_if.underflow} !== 2'b00) begin errors++; $display("FAIL reset_flags got %b want 00", {ff_if.overflow, ff_if.underflow}); end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (ff_if.empty !== 1'b1 || ff_if.count !== 3'd0) begin errors++; $display("FAIL post_reset_idle got empty=%b count=%0d want 1/0", ff_if.empty, ff_if.count); end
  endtask

  task automatic test_async_reset;
    for (int i = 1; i <= 3; i++) cyc(1'b1, 8'(i), 1'b0);
    checks++; if (ff_if.count !== 3'd3) begin errors++; $display("FAIL arst_precount got %0d want 3", ff_if.count); end
    #3 rst_n = 1'b0;
    #1;
    checks++; if (ff_if.count !== 3'd0) begin errors++; $display("FAIL arst_count got %0d want 0", ff_if.count); end
    checks++; if (ff_if.empty !== 1'b1) begin errors++; $display("FAIL arst_empty got %b want 1", ff_if.empty); end
    checks++; if (ff_if.full !== 1'b0) begin errors++; $display("FAIL arst_full got %b want 0", ff_if.full); end
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_fill_drain;
    logic [7:0] exp;
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, 8'(8'h11 * (i + 1)), 1'b0);
      checks++; if (ff_if.count !== 3'(i + 1)) begin errors++; $display("FAIL fill_count got %0d want %0d", ff_if.count, i + 1); end
      if (i == 0) begin
        checks++; if (ff_if.empty !== 1'b0 || ff_if.rd_data !== 8'h11) begin errors++; $display("FAIL first_word_latency got empty=%b data=%h want 0/11", ff_if.empty, ff_if.rd_data); end
      end
    end
    checks++; if (ff_if.full !== 1'b1) begin errors++; $display("FAIL fill_full got %b want 1", ff_if.full); end
    for (int i = 0; i < 4; i++) begin
      exp = 8'(8'h11 * (i + 1));
      checks++; if (ff_if.rd_data !== exp) begin errors++; $display("FAIL drain_data got %h want %h", ff_if.rd_data, exp); end
      cyc(1'b0, 8'h00, 1'b1);
    end
    checks++; if (ff_if.empty !== 1'b1 || ff_if.count !== 3'd0) begin errors++; $display("FAIL drain_empty got empty=%b count=%0d want 1/0", ff_if.empty, ff_if.count); end
  endtask

  task automatic test_overflow;
    logic [7:0] exp;
    for (int i = 0; i < 4; i++) cyc(1'b1, 8'(8'h11 * (i + 1)), 1'b0);
    checks++; if (ff_if.overflow !== 1'b0) begin errors++; $display("FAIL ovf_early got %b want 0", ff_if.overflow); end
    cyc(1'b1, 8'h55, 1'b0);
    checks++; if (ff_if.overflow !== 1'b1) begin errors++; $display("FAIL ovf_pulse got %b want 1", ff_if.overflow); end
    checks++; if (ff_if.count !== 3'd4 || ff_if.full !== 1'b1) begin errors++; $display("FAIL ovf_count got count=%0d full=%b want 4/1", ff_if.count, ff_if.full); end
    checks++; if (ff_if.rd_data !== 8'h11) begin errors++; $display("FAIL ovf_head got %h want 11", ff_if.rd_data); end
    cyc(1'b0, 8'h00, 1'b0);
    checks++; if (ff_if.overflow !== 1'b0) begin errors++; $display("FAIL ovf_one_cycle got %b want 0", ff_if.overflow); end
    for (int i = 0; i < 4; i++) begin
      exp = 8'(8'h11 * (i + 1));
      checks++; if (ff_if.rd_data !== exp) begin errors++; $display("FAIL ovf_drain got %h want %h", ff_if.rd_data, exp); end
      cyc(1'b0, 8'h00, 1'b1);
    end
    checks++; if (ff_if.empty !== 1'b1) begin errors++; $display("FAIL ovf_dropped got empty=%b want 1", ff_if.empty); end
  endtask

  task automatic test_underflow;
    cyc(1'b0, 8'h00, 1'b1);
    checks++; if (ff_if.underflow !== 1'b1 || ff_if.count !== 3'd0) begin errors++; $display("FAIL udf_read_only got udf=%b count=%0d want 1/0", ff_if.underflow, ff_if.count); end
    cyc(1'b1, 8'hA5, 1'b1);
    checks++; if (ff_if.underflow !== 1'b1) begin errors++; $display("FAIL udf_pulse got %b want 1", ff_if.underflow); end
    checks++; if (ff_if.count !== 3'd1 || ff_if.empty !== 1'b0) begin errors++; $display("FAIL udf_count got count=%0d empty=%b want 1/0", ff_if.count, ff_if.empty); end
    checks++; if (ff_if.rd_data !== 8'hA5) begin errors++; $display("FAIL udf_data got %h want a5", ff_if.rd_data); end
    cyc(1'b0, 8'h00, 1'b0);
    checks++; if (ff_if.underflow !== 1'b0) begin errors++; $display("FAIL udf_one_cycle got %b want 0", ff_if.underflow); end
    cyc(1'b0, 8'h00, 1'b1);
    checks++; if (ff_if.empty !== 1'b1 || ff_if.underflow !== 1'b0) begin errors++; $display("FAIL udf_drain got empty=%b udf=%b want 1/0", ff_if.empty, ff_if.underflow); end
  endtask

  task automatic test_full_rw;
    logic [7:0] exp [4] = '{8'h22, 8'h33, 8'h44, 8'h66};
    for (int i = 0; i < 4; i++) cyc(1'b1, 8'(8'h11 * (i + 1)), 1'b0);
    cyc(1'b1, 8'h66, 1'b1);
    checks++; if (ff_if.count !== 3'd4 || ff_if.full !== 1'b1) begin errors++; $display("FAIL frw_count got count=%0d full=%b want 4/1", ff_if.count, ff_if.full); end
    checks++; if (ff_if.overflow !== 1'b0) begin errors++; $display("FAIL frw_no_ovf got %b want 0", ff_if.overflow); end
    checks++; if (ff_if.rd_data !== 8'h22) begin errors++; $display("FAIL frw_head got %h want 22", ff_if.rd_data); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (ff_if.rd_data !== exp[i]) begin errors++; $display("FAIL frw_drain got %h want %h", ff_if.rd_data, exp[i]); end
      cyc(1'b0, 8'h00, 1'b1);
    end
    checks++; if (ff_if.empty !== 1'b1) begin errors++; $display("FAIL frw_empty got %b want 1", ff_if.empty); end
  endtask

  task automatic test_wrap;
    cyc(1'b1, 8'd0, 1'b0);
    for (int i = 1; i <= 9; i++) begin
      cyc(1'b1, 8'(i), 1'b0);
      checks++; if (ff_if.count !== 3'd2) begin errors++; $display("FAIL wrap_count2 got %0d want 2", ff_if.count); end
      checks++; if (ff_if.rd_data !== 8'(i - 1)) begin errors++; $display("FAIL wrap_data got %h want %h", ff_if.rd_data, 8'(i - 1)); end
      cyc(1'b0, 8'h00, 1'b1);
      checks++; if (ff_if.count !== 3'd1 || {ff_if.overflow, ff_if.underflow} !== 2'b00) begin errors++; $display("FAIL wrap_step got count=%0d flags=%b want 1/00", ff_if.count, {ff_if.overflow, ff_if.underflow}); end
    end
    checks++; if (ff_if.rd_data !== 8'd9) begin errors++; $display("FAIL wrap_last got %h want 09", ff_if.rd_data); end
    cyc(1'b0, 8'h00, 1'b1);
    checks++; if (ff_if.empty !== 1'b1 || {ff_if.overflow, ff_if.underflow} !== 2'b00) begin errors++; $display("FAIL wrap_end got empty=%b flags=%b want 1/00", ff_if.empty, {ff_if.overflow, ff_if.underflow}); end
  endtask

  initial begin
    test_reset();
    test_async_reset();
    test_fill_drain();
    test_overflow();
    test_underflow();
    test_full_rw();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
